// File: rtl/aes_req_arbiter.sv
// Round-robin arbiter sharing one AES core between N requesters.
// Latches the winning key/plaintext, sequences load/run/done and returns the result to the owner.
module aes_req_arbiter #(
  parameter int N           = 4,
  parameter int K           = 128,
  parameter int LOAD_CYCLES = 8,
  parameter int TIMEOUT     = 4096
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req_valid,
  output logic [N-1:0]     req_ready,
  input  logic [N*K-1:0]   req_key,
  input  logic [N*128-1:0] req_text,
  output logic [N-1:0]     rsp_valid,
  output logic             rsp_err,
  output logic [127:0]     rsp_data,
  output logic             core_ce,
  output logic [K-1:0]     core_key,
  output logic [127:0]     core_plaintext,
  input  logic             core_done,
  input  logic [127:0]     core_cyphertext
);

  localparam int IW = $clog2(N);
  localparam int LW = $clog2(LOAD_CYCLES + 1);
  localparam int RW = $clog2(TIMEOUT + 1);
  localparam logic [LW-1:0] LOAD_LAST = LW'(LOAD_CYCLES - 1);
  localparam logic [RW-1:0] RUN_LAST  = RW'(TIMEOUT - 1);
  localparam logic [IW-1:0] LAST_ID   = IW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_RESP} state_t;

  // Handshake: a request transfers in a cycle where req_valid[i] and req_ready[i] are both 1;
  // requesters hold valid and data stable until then, and rsp_valid is a single unstalled pulse.
  state_t          state, state_next;
  logic [IW-1:0]   ptr, owner, win, idx;
  logic [IW:0]     sum;
  logic            any_valid;
  logic [LW-1:0]   load_cnt;
  logic [RW-1:0]   run_cnt;
  logic            done_q, low_seen, done_ok;
  logic [K-1:0]    sel_key;
  logic [127:0]    sel_text;

  // Scan from ptr+N-1 down to ptr so the closest valid requester after ptr wins.
  always_comb begin
    win       = '0;
    idx       = '0;
    sum       = '0;
    any_valid = |req_valid;
    for (int k = N - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (IW + 1)'(k);
      if (sum >= (IW + 1)'(N)) sum = sum - (IW + 1)'(N);
      idx = sum[IW-1:0];
      if (req_valid[idx]) win = idx;
    end
  end

  always_comb begin
    sel_key  = '0;
    sel_text = '0;
    for (int i = 0; i < N; i++) begin
      if (win == IW'(i)) begin
        sel_key  = req_key[i*K +: K];
        sel_text = req_text[i*128 +: 128];
      end
    end
  end

  // A done level is only trusted after the core was seen low during this RUN.
  assign done_ok = done_q && low_seen;

  always_comb begin
    state_next = state;
    req_ready  = '0;
    rsp_valid  = '0;
    core_ce    = 1'b0;
    case (state)
      S_IDLE: begin
        if (any_valid) begin
          req_ready[win] = 1'b1;
          state_next     = S_LOAD;
        end
      end
      S_LOAD: begin
        core_ce = 1'b1;
        if (load_cnt == LOAD_LAST) state_next = S_RUN;
      end
      S_RUN: begin
        if (done_ok || run_cnt == RUN_LAST) state_next = S_RESP;
      end
      S_RESP: begin
        rsp_valid[owner] = 1'b1;
        state_next       = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      ptr            <= '0;
      owner          <= '0;
      load_cnt       <= '0;
      run_cnt        <= '0;
      done_q         <= 1'b0;
      low_seen       <= 1'b0;
      rsp_err        <= 1'b0;
      rsp_data       <= '0;
      core_key       <= '0;
      core_plaintext <= '0;
    end else begin
      state  <= state_next;
      done_q <= core_done;
      case (state)
        S_IDLE: begin
          if (any_valid) begin
            core_key       <= sel_key;
            core_plaintext <= sel_text;
            owner          <= win;
            ptr            <= (win == LAST_ID) ? '0 : win + 1'b1;
            load_cnt       <= '0;
          end
        end
        S_LOAD: begin
          load_cnt <= load_cnt + 1'b1;
          low_seen <= 1'b0;
          run_cnt  <= '0;
        end
        S_RUN: begin
          run_cnt <= run_cnt + 1'b1;
          if (!done_q) low_seen <= 1'b1;
          if (done_ok) begin
            rsp_data <= core_cyphertext;
            rsp_err  <= 1'b0;
          end else if (run_cnt == RUN_LAST) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
